stun_timer: RTL and testbench

STUN_TIMER -- requirements
Module: stun_timer

---
 rtl/stun_timer.sv | 132 +++++++++++++
 tb/tb_stun_timer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stun_timer.sv
`default_nettype none
// ============================================================================
// Module  : stun_timer
// Purpose : Per-player stun / immunity sequencer counted in video frames.
// Rev     : 1.0 - initial release
// ============================================================================
module stun_timer #(
    parameter int STUN_FRAMES   = 60,
    parameter int IMMUNE_FRAMES = 30,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       game_active,
    input  logic       red_hit,
    input  logic       blue_hit,
    output logic       red_stunned,
    output logic       blue_stunned,
    output logic       red_immune,
    output logic       blue_immune,
    output logic       red_stun_event,
    output logic       blue_stun_event,
    output logic [3:0] red_stun_tally,
    output logic [3:0] blue_stun_tally
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STUNNED = 2'd1,
        IMMUNE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_stunLoad   = CNT_W'(STUN_FRAMES);
    localparam logic [CNT_W-1:0] c_immuneLoad = CNT_W'(IMMUNE_FRAMES);
    localparam logic [CNT_W-1:0] c_cntOne     = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cntZero    = '0;
    localparam logic [3:0]       c_tallyMax   = 4'd15;

    logic [1:0] w_hit;
    logic [1:0] w_stunned;
    logic [1:0] w_immune;
    logic [1:0] w_event;
    logic [3:0] w_tally [2];

    assign w_hit = {blue_hit, red_hit};

    // Index 0 is red, index 1 is blue; both players run the same sequencer.
    generate
        for (genvar p = 0; p < 2; p++) begin : g_player
            state_t           r_state;
            logic [CNT_W-1:0] r_cnt;
            logic             r_event;
            logic [3:0]       r_tally;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_state <= IDLE;
                    r_cnt   <= c_cntZero;
                    r_event <= 1'b0;
                    r_tally <= 4'd0;
                end else if (!game_active) begin
                    r_state <= IDLE;
                    r_cnt   <= c_cntZero;
                    r_event <= 1'b0;
                    r_tally <= 4'd0;
                end else begin
                    r_event <= 1'b0;
                    case (r_state)
                        // A tick in the hit cycle is deliberately ignored so
                        // the new stun always gets its full frame count.
                        IDLE: begin
                            if (w_hit[p]) begin
                                r_state <= STUNNED;
                                r_cnt   <= c_stunLoad;
                                r_event <= 1'b1;
                                if (r_tally != c_tallyMax) begin
                                    r_tally <= r_tally + 4'd1;
                                end
                            end
                        end
                        STUNNED: begin
                            if (frame_tick) begin
                                if (r_cnt <= c_cntOne) begin
                                    if (IMMUNE_FRAMES == 0) begin
                                        r_state <= IDLE;
                                        r_cnt   <= c_cntZero;
                                    end else begin
                                        r_state <= IMMUNE;
                                        r_cnt   <= c_immuneLoad;
                                    end
                                end else begin
                                    r_cnt <= r_cnt - c_cntOne;
                                end
                            end
                        end
                        IMMUNE: begin
                            if (frame_tick) begin
                                if (r_cnt <= c_cntOne) begin
                                    r_state <= IDLE;
                                    r_cnt   <= c_cntZero;
                                end else begin
                                    r_cnt <= r_cnt - c_cntOne;
                                end
                            end
                        end
                        default: begin
                            r_state <= IDLE;
                            r_cnt   <= c_cntZero;
                        end
                    endcase
                end
            end

            assign w_stunned[p] = (r_state == STUNNED);
            assign w_immune[p]  = (r_state == IMMUNE);
            assign w_event[p]   = r_event;
            assign w_tally[p]   = r_tally;
        end
    endgenerate

    assign red_stunned     = w_stunned[0];
    assign blue_stunned    = w_stunned[1];
    assign red_immune      = w_immune[0];
    assign blue_immune     = w_immune[1];
    assign red_stun_event  = w_event[0];
    assign blue_stun_event = w_event[1];
    assign red_stun_tally  = w_tally[0];
    assign blue_stun_tally = w_tally[1];

endmodule
`default_nettype wire

// File: tb/tb_stun_timer.sv
`default_nettype none
// ============================================================================
// Module  : tb_stun_timer
// Purpose : Scoreboard bench for stun_timer (STUN=3, IMMUNE=2, CNT_W=8).
// Rev     : 1.0 - initial release
// ============================================================================
module tb_stun_timer;

    localparam int SF = 3;
    localparam int IF = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic       game_active;
    logic       red_hit;
    logic       blue_hit;
    logic       red_stunned, blue_stunned, red_immune, blue_immune;
    logic       red_stun_event, blue_stun_event;
    logic [3:0] red_stun_tally, blue_stun_tally;

    stun_timer #(.STUN_FRAMES(SF), .IMMUNE_FRAMES(IF), .CNT_W(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .frame_tick      (frame_tick),
        .game_active     (game_active),
        .red_hit         (red_hit),
        .blue_hit        (blue_hit),
        .red_stunned     (red_stunned),
        .blue_stunned    (blue_stunned),
        .red_immune      (red_immune),
        .blue_immune     (blue_immune),
        .red_stun_event  (red_stun_event),
        .blue_stun_event (blue_stun_event),
        .red_stun_tally  (red_stun_tally),
        .blue_stun_tally (blue_stun_tally)
    );

    always #5 clk = ~clk;

    // Packed view: [13]rs [12]bs [11]ri [10]bi [9]re [8]be [7:4]rt [3:0]bt
    wire [13:0] act = {red_stunned, blue_stunned, red_immune, blue_immune,
                       red_stun_event, blue_stun_event,
                       red_stun_tally, blue_stun_tally};

    int checks = 0;
    int fails  = 0;
    logic [13:0] sb[$];
    logic [13:0] exp;

    // Reference model: phase 0 idle, 1 frozen, 2 immune; frames left in mLeft.
    int   mPhase [2];
    int   mLeft  [2];
    int   mCount [2];
    logic mPulse [2];

    task automatic modelReset();
        for (int p = 0; p < 2; p++) begin
            mPhase[p] = 0; mLeft[p] = 0; mCount[p] = 0; mPulse[p] = 1'b0;
        end
    endtask

    task automatic modelStep(input logic rh, input logic bh, input logic tk, input logic ga);
        logic hit [2];
        hit[0] = rh; hit[1] = bh;
        for (int p = 0; p < 2; p++) begin
            mPulse[p] = 1'b0;
            if (!ga) begin
                mPhase[p] = 0; mLeft[p] = 0; mCount[p] = 0;
            end else if (mPhase[p] == 0) begin
                if (hit[p]) begin
                    mPhase[p] = 1; mLeft[p] = SF; mPulse[p] = 1'b1;
                    mCount[p] = (mCount[p] >= 15) ? 15 : mCount[p] + 1;
                end
            end else if (tk) begin
                mLeft[p] = mLeft[p] - 1;
                if (mLeft[p] == 0) begin
                    if (mPhase[p] == 1 && IF > 0) begin
                        mPhase[p] = 2; mLeft[p] = IF;
                    end else begin
                        mPhase[p] = 0;
                    end
                end
            end
        end
    endtask

    function automatic logic [13:0] modelOut();
        return {mPhase[0] == 1, mPhase[1] == 1, mPhase[0] == 2, mPhase[1] == 2,
                mPulse[0], mPulse[1], 4'(mCount[0]), 4'(mCount[1])};
    endfunction

    // Drive one cycle, queue the expected result, land #1 after the edge.
    task automatic cycle(input logic rh, input logic bh, input logic tk, input logic ga);
        red_hit = rh; blue_hit = bh; frame_tick = tk; game_active = ga;
        modelStep(rh, bh, tk, ga);
        sb.push_back(modelOut());
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; red_hit = 1'b0; blue_hit = 1'b0;
        frame_tick = 1'b0; game_active = 1'b1;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (act !== 14'd0) begin
            fails++;
            $display("FAIL reset_state: got %b expected %b", act, 14'd0);
        end
        reset = 1'b0;
    endtask

    task automatic test_single_stun();
        int events = 0, stunTicks = 0, immTicks = 0;
        for (int i = 0; i < 30; i++) begin
            logic tk;
            tk = (i % 4 == 2);
            if (tk && red_stunned) stunTicks++;
            if (tk && red_immune)  immTicks++;
            cycle(i == 0, 1'b0, tk, 1'b1);
            if (act[9]) events++;
            exp = sb.pop_front(); checks++;
            if (act !== exp) begin
                fails++;
                $display("FAIL single_sb cyc%0d: got %b expected %b", i, act, exp);
            end
        end
        checks++;
        if (events != 1 || stunTicks != SF || immTicks != IF || red_stun_tally !== 4'd1) begin
            fails++;
            $display("FAIL single_summary: ev=%0d stunTicks=%0d immTicks=%0d tally=%0d expected 1/3/2/1",
                     events, stunTicks, immTicks, red_stun_tally);
        end
    endtask

    task automatic test_held_hit();
        int events = 0;
        logic busy;
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        exp = sb.pop_front(); checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL held_clear: got %b expected %b", act, exp);
        end
        for (int i = 0; i < 40; i++) begin
            busy = red_stunned | red_immune;
            cycle(1'b1, 1'b0, (i % 4 == 0), 1'b1);
            if (act[9]) events++;
            exp = sb.pop_front(); checks++;
            if (act !== exp) begin
                fails++;
                $display("FAIL held_sb cyc%0d: got %b expected %b", i, act, exp);
            end
            checks++;
            if (act[9] && busy) begin
                fails++;
                $display("FAIL held_busy_event cyc%0d: got event=1 expected 0", i);
            end
        end
        checks++;
        if (events != 2 || red_stun_tally !== 4'd2) begin
            fails++;
            $display("FAIL held_summary: events=%0d tally=%0d expected 2/2", events, red_stun_tally);
        end
        for (int i = 0; i < 25; i++) begin
            cycle(1'b0, 1'b0, (i % 4 == 0), 1'b1);
            exp = sb.pop_front(); checks++;
            if (act !== exp) begin
                fails++;
                $display("FAIL held_drain cyc%0d: got %b expected %b", i, act, exp);
            end
        end
    endtask

    task automatic test_simultaneous();
        int rTicks = 0, bTicks = 0;
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        exp = sb.pop_front();
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        exp = sb.pop_front(); checks++;
        if (act !== exp || act[13:12] !== 2'b11 || act[9:8] !== 2'b11) begin
            fails++;
            $display("FAIL simul_entry: got %b expected %b", act, exp);
        end
        for (int i = 0; i < 24; i++) begin
            logic tk;
            tk = (i % 4 == 3);
            if (tk && red_stunned)  rTicks++;
            if (tk && blue_stunned) bTicks++;
            cycle(1'b0, 1'b0, tk, 1'b1);
            exp = sb.pop_front(); checks++;
            if (act !== exp) begin
                fails++;
                $display("FAIL simul_sb cyc%0d: got %b expected %b", i, act, exp);
            end
        end
        checks++;
        if (rTicks != SF || bTicks != SF) begin
            fails++;
            $display("FAIL simul_ticks: red=%0d blue=%0d expected %0d", rTicks, bTicks, SF);
        end
    endtask

    task automatic test_saturate();
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        exp = sb.pop_front();
        for (int k = 0; k < 16; k++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b1);
            exp = sb.pop_front(); checks++;
            if (act !== exp) begin
                fails++;
                $display("FAIL sat_entry stun%0d: got %b expected %b", k, act, exp);
            end
            for (int j = 0; j < 6; j++) begin
                cycle(1'b0, 1'b0, 1'b1, 1'b1);
                exp = sb.pop_front(); checks++;
                if (act !== exp) begin
                    fails++;
                    $display("FAIL sat_run stun%0d/%0d: got %b expected %b", k, j, act, exp);
                end
            end
        end
        checks++;
        if (red_stun_tally !== 4'd15 || blue_stun_tally !== 4'd0) begin
            fails++;
            $display("FAIL sat_tally: red=%0d blue=%0d expected 15/0", red_stun_tally, blue_stun_tally);
        end
    endtask

    task automatic test_async_reset();
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        exp = sb.pop_front();
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        exp = sb.pop_front();
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        exp = sb.pop_front(); checks++;
        if (act !== exp || blue_stunned !== 1'b1) begin
            fails++;
            $display("FAIL areset_pre: got %b expected %b", act, exp);
        end
        #3 reset = 1'b1;
        #1;
        checks++;
        if (act !== 14'd0) begin
            fails++;
            $display("FAIL areset_async_clear: got %b expected %b", act, 14'd0);
        end
        #2 reset = 1'b0;
        modelReset();
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        exp = sb.pop_front(); checks++;
        if (act !== exp || blue_stunned !== 1'b1 || blue_stun_event !== 1'b1) begin
            fails++;
            $display("FAIL areset_first_hit: got %b expected %b", act, exp);
        end
    endtask

    task automatic test_game_inactive();
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        exp = sb.pop_front();
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        exp = sb.pop_front();
        repeat (3) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b1);
            exp = sb.pop_front();
        end
        checks++;
        if (act !== exp || red_immune !== 1'b1) begin
            fails++;
            $display("FAIL inactive_pre: got %b expected %b", act, exp);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        exp = sb.pop_front(); checks++;
        if (act !== exp || red_immune !== 1'b0 || red_stun_tally !== 4'd0) begin
            fails++;
            $display("FAIL inactive_clear: got %b expected %b", act, exp);
        end
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        exp = sb.pop_front(); checks++;
        if (act !== exp || red_stun_event !== 1'b0 || red_stunned !== 1'b0) begin
            fails++;
            $display("FAIL inactive_hit_ignored: got %b expected %b", act, exp);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        exp = sb.pop_front(); checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL inactive_resume: got %b expected %b", act, exp);
        end
    endtask

    initial begin
        test_reset();
        test_single_stun();
        test_held_hit();
        test_simultaneous();
        test_saturate();
        test_async_reset();
        test_game_inactive();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
